// File: rtl/cpu_types_pkg.sv
// Shared types for the memory request unit: FSM state encoding.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        REQ_IFETCH  = 2'd0,
        REQ_DACCESS = 2'd1,
        REQ_HALTED  = 2'd2
    } reqstate_t;

    localparam int unsigned REQ_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/req_watchdog.sv
// Watchdog counter: counts enabled cycles since the last clear and flags
// when the count reaches TIMEOUT_CYCLES. Used only in REQ_TIMEOUT_EN builds.
module req_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = cpu_types_pkg::REQ_TIMEOUT_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_count;

    // Saturates at the limit so expired stays asserted until cleared.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_en && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/memory_request_unit.sv
// Sequences instruction fetch and data access for a single-issue core.
// Optional watchdog enabled by defining REQ_TIMEOUT_EN.
module memory_request_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = REQ_TIMEOUT_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic MemRd,
    input  logic MemWr,
    input  logic halt,
    input  logic ihit,
    input  logic dhit,
    output logic iREN,
    output logic dREN,
    output logic dWEN,
    output logic pc_en,
    output logic halted,
    output logic timeout
);

    reqstate_t r_state;
    reqstate_t w_next_state;
    logic      r_rd_q;
    logic      r_wr_q;
    logic      w_rd_d;
    logic      w_wr_d;
    logic      w_expired;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= REQ_IFETCH;
            r_rd_q  <= 1'b0;
            r_wr_q  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_rd_q  <= w_rd_d;
            r_wr_q  <= w_wr_d;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_rd_d       = r_rd_q;
        w_wr_d       = r_wr_q;
        iREN         = 1'b0;
        dREN         = 1'b0;
        dWEN         = 1'b0;
        pc_en        = 1'b0;
        halted       = 1'b0;
        case (r_state)
            REQ_IFETCH: begin
                iREN = 1'b1;
                if (ihit) begin
                    if (halt) begin
                        w_next_state = REQ_HALTED;
                    end else if (MemRd || MemWr) begin
                        w_rd_d       = MemRd & ~MemWr;
                        w_wr_d       = MemWr;
                        w_next_state = REQ_DACCESS;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            REQ_DACCESS: begin
                dREN = r_rd_q;
                dWEN = r_wr_q;
                if (dhit) begin
                    pc_en        = 1'b1;
                    w_rd_d       = 1'b0;
                    w_wr_d       = 1'b0;
                    w_next_state = REQ_IFETCH;
                end
            end
            REQ_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                w_next_state = REQ_IFETCH;
            end
        endcase
        // A timeout overrides any hit arriving in the same cycle.
        if (w_expired) begin
            pc_en        = 1'b0;
            w_rd_d       = 1'b0;
            w_wr_d       = 1'b0;
            w_next_state = REQ_HALTED;
        end
    end

`ifdef REQ_TIMEOUT_EN
    logic w_awaited_hit;
    logic w_wd_clear;
    logic w_wd_count_en;
    logic r_timeout;

    assign w_awaited_hit = ((r_state == REQ_IFETCH)  && ihit) ||
                           ((r_state == REQ_DACCESS) && dhit);
    assign w_wd_clear    = w_awaited_hit || (w_next_state != r_state);
    assign w_wd_count_en = (r_state != REQ_HALTED) && !w_awaited_hit;

    req_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (w_wd_clear),
        .count_en (w_wd_count_en),
        .expired  (w_expired)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_timeout <= 1'b0;
        end else if (w_expired) begin
            r_timeout <= 1'b1;
        end
    end

    // Visible in the cycle the limit is reached; halted follows next cycle.
    assign timeout = r_timeout | w_expired;
`else
    assign w_expired = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_memory_request_unit.sv
// Directed self-checking bench for memory_request_unit.
module tb_memory_request_unit;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic MemRd = 1'b0, MemWr = 1'b0, halt = 1'b0, ihit = 1'b0, dhit = 1'b0;
    logic iREN, dREN, dWEN, pc_en, halted, timeout;

    int n_tests = 0;
    int n_fail  = 0;

    memory_request_unit #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .MemRd   (MemRd),
        .MemWr   (MemWr),
        .halt    (halt),
        .ihit    (ihit),
        .dhit    (dhit),
        .iREN    (iREN),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .pc_en   (pc_en),
        .halted  (halted),
        .timeout (timeout)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        MemRd = 1'b0; MemWr = 1'b0; halt = 1'b0; ihit = 1'b0; dhit = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1'b1;
        #2;
        n_tests++;
        if ({iREN, dREN, dWEN, pc_en, halted, timeout} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 100000",
                     {iREN, dREN, dWEN, pc_en, halted, timeout});
        end
        n_tests++;
        if (dut.r_state !== REQ_IFETCH) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want %0d", dut.r_state, REQ_IFETCH);
        end
        tick();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_add();
        logic exp_pc;
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            ihit = (c == 3 || c == 5 || c == 7);
            #1;
            exp_pc = (c == 3 || c == 5 || c == 7);
            n_tests++;
            if ({iREN, dREN, dWEN, pc_en} !== {1'b1, 1'b0, 1'b0, exp_pc}) begin
                n_fail++;
                $display("FAIL add_c%0d: iREN/dREN/dWEN/pc_en got %b want %b",
                         c, {iREN, dREN, dWEN, pc_en}, {1'b1, 1'b0, 1'b0, exp_pc});
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_lw();
        logic [2:0] exp;
        do_reset();
        MemRd = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            ihit = (c == 2 || c == 4);
            dhit = (c == 6);
            #1;
            exp = {!(c >= 3 && c <= 6), (c >= 3 && c <= 6), (c == 6)};
            n_tests++;
            if ({iREN, dREN, pc_en} !== exp || dWEN !== 1'b0) begin
                n_fail++;
                $display("FAIL lw_c%0d: iREN/dREN/pc_en got %b want %b dWEN %b",
                         c, {iREN, dREN, pc_en}, exp, dWEN);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_store_wins();
        do_reset();
        dhit = 1'b1;
        #1;
        n_tests++;
        if ({iREN, pc_en} !== 2'b10) begin
            n_fail++;
            $display("FAIL dhit_in_ifetch: iREN/pc_en got %b want 10", {iREN, pc_en});
        end
        tick();
        dhit = 1'b0; MemRd = 1'b1; MemWr = 1'b1; ihit = 1'b1;
        #1;
        n_tests++;
        if (pc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL both_issue_pc: got %b want 0", pc_en);
        end
        tick();
        clear_inputs();
        #1;
        n_tests++;
        if ({iREN, dREN, dWEN} !== 3'b001) begin
            n_fail++;
            $display("FAIL both_daccess: iREN/dREN/dWEN got %b want 001", {iREN, dREN, dWEN});
        end
        dhit = 1'b1;
        #1;
        n_tests++;
        if (pc_en !== 1'b1) begin
            n_fail++;
            $display("FAIL both_dhit_pc: got %b want 1", pc_en);
        end
        tick();
        dhit = 1'b0;
        #1;
        n_tests++;
        if ({iREN, dREN, dWEN, pc_en} !== 4'b1000) begin
            n_fail++;
            $display("FAIL both_return: got %b want 1000", {iREN, dREN, dWEN, pc_en});
        end
    endtask

    task automatic test_halt();
        do_reset();
        halt = 1'b1; MemWr = 1'b1; ihit = 1'b1;
        #1;
        n_tests++;
        if ({pc_en, dWEN, halted} !== 3'b000) begin
            n_fail++;
            $display("FAIL halt_issue: pc_en/dWEN/halted got %b want 000", {pc_en, dWEN, halted});
        end
        tick();
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            ihit = c[0];
            dhit = ~c[0];
            #1;
            n_tests++;
            if ({halted, iREN, dREN, dWEN, pc_en} !== 5'b10000) begin
                n_fail++;
                $display("FAIL halted_c%0d: halted/iREN/dREN/dWEN/pc_en got %b want 10000",
                         c, {halted, iREN, dREN, dWEN, pc_en});
            end
            tick();
        end
        clear_inputs();
        do_reset();
        n_tests++;
        if ({halted, iREN} !== 2'b01) begin
            n_fail++;
            $display("FAIL halt_reset: halted/iREN got %b want 01", {halted, iREN});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        MemWr = 1'b1; ihit = 1'b1;
        tick();
        clear_inputs();
        #1;
        n_tests++;
        if (dWEN !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre: dWEN got %b want 1", dWEN);
        end
        #1;
        RST = 1'b1;
        #1;
        n_tests++;
        if ({dWEN, iREN} !== 2'b01) begin
            n_fail++;
            $display("FAIL arst_drop: dWEN/iREN got %b want 01", {dWEN, iREN});
        end
        #1;
        RST = 1'b0;
        tick();
        n_tests++;
        if ({iREN, dREN, dWEN} !== 3'b100 || dut.r_state !== REQ_IFETCH) begin
            n_fail++;
            $display("FAIL arst_after: iREN/dREN/dWEN got %b want 100 state %0d",
                     {iREN, dREN, dWEN}, dut.r_state);
        end
    endtask

`ifdef REQ_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        MemRd = 1'b1; ihit = 1'b1;
        tick();
        clear_inputs();
        for (int c = 1; c <= 8; c++) begin
            #1;
            n_tests++;
            if ({timeout, halted, dREN} !== 3'b001) begin
                n_fail++;
                $display("FAIL to_wait%0d: timeout/halted/dREN got %b want 001",
                         c, {timeout, halted, dREN});
            end
            tick();
        end
        #1;
        n_tests++;
        if ({timeout, halted} !== 2'b10) begin
            n_fail++;
            $display("FAIL to_flag: timeout/halted got %b want 10", {timeout, halted});
        end
        tick();
        n_tests++;
        if ({timeout, halted} !== 2'b11) begin
            n_fail++;
            $display("FAIL to_halted: timeout/halted got %b want 11", {timeout, halted});
        end
        do_reset();
        MemRd = 1'b1; ihit = 1'b1;
        tick();
        clear_inputs();
        for (int c = 1; c <= 10; c++) begin
            dhit = (c == 7);
            ihit = (c > 7);
            #1;
            n_tests++;
            if ({timeout, halted} !== 2'b00 || pc_en !== (c >= 7)) begin
                n_fail++;
                $display("FAIL to_early%0d: timeout/halted/pc_en got %b want 00%b",
                         c, {timeout, halted, pc_en}, (c >= 7));
            end
            tick();
        end
        clear_inputs();
    endtask
`else
    task automatic test_timeout();
        do_reset();
        MemRd = 1'b1; ihit = 1'b1;
        tick();
        clear_inputs();
        for (int c = 1; c <= 100; c++) tick();
        n_tests++;
        if ({timeout, halted, dREN, iREN} !== 4'b0010) begin
            n_fail++;
            $display("FAIL unbounded_wait: timeout/halted/dREN/iREN got %b want 0010",
                     {timeout, halted, dREN, iREN});
        end
        dhit = 1'b1;
        #1;
        n_tests++;
        if (pc_en !== 1'b1) begin
            n_fail++;
            $display("FAIL unbounded_dhit: pc_en got %b want 1", pc_en);
        end
        tick();
        clear_inputs();
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_add();
        test_lw();
        test_store_wins();
        test_halt();
        test_async_reset();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
